onehot_req_encoder: RTL and testbench

- Sequential 4-to-2 encoder; inverse of the team's 2-to-4 one-hot decoder.
- Latches up to four single-bit request lines and reports one pending request at a time as a 2-bit binary code.
- Code mapping is the decoder's inverse: req[3] <-> 2'b11, req[2] <-> 2'b10, req[1] <-> 2'b01, req[0] <-> 2'b00.
- Each code is presented with a valid/ack handshake to a downstream consumer, e.g. a service sequencer or the decoder itself.

---
 rtl/onehot_req_encoder.sv | 105 ++++++++++
 tb/tb_onehot_req_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_req_encoder.sv
// Sequential 4-to-2 request encoder with a valid/ack handshake; inverse of the 2-to-4 one-hot decoder.
// Optional round-robin priority is enabled with `define ONEHOT_REQ_ENCODER_RR_EN (default: fixed highest-index-first).
//
// state   | meaning
// IDLE    | no code presented; pick the next pending request, if any
// PRESENT | code held with valid=1 until the consumer acks
module onehot_req_encoder (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req,
   input  logic       ack,
   output logic [1:0] code,
   output logic       valid,
   output logic [3:0] pending,
   output logic       overrun
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t     state_q;
   logic [1:0] code_q;
   logic       valid_q;
   logic [3:0] pending_q;
   logic       overrun_q;

   logic [3:0] clr;
   logic [3:0] pending_d;
   logic       overrun_d;
   logic [1:0] sel;

   always_comb begin
      clr = 4'b0000;
      if (valid_q && ack) clr[code_q] = 1'b1;
   end

   // a request re-arriving in the same cycle its grant is acked re-arms the bit without an error
   assign pending_d = (pending_q & ~clr) | req;
   assign overrun_d = overrun_q | (|(req & pending_q & ~clr));

`ifdef ONEHOT_REQ_ENCODER_RR_EN
   logic [1:0] ptr_q;
   logic [1:0] idx;

   // walk from ptr-4 (== ptr, lowest priority) up to ptr-1 so the last hit is the highest priority
   always_comb begin
      sel = 2'b00;
      idx = 2'b00;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr_q - 2'(i);
         if (pending_q[idx]) sel = idx;
      end
   end
`else
   always_comb begin
      sel = 2'b00;
      for (int i = 0; i < 4; i++) begin
         if (pending_q[i]) sel = 2'(i);
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         code_q    <= 2'b00;
         valid_q   <= 1'b0;
         pending_q <= 4'b0000;
         overrun_q <= 1'b0;
`ifdef ONEHOT_REQ_ENCODER_RR_EN
         ptr_q     <= 2'b00;
`endif
      end else begin
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         case (state_q)
            IDLE: begin
               if (pending_q != 4'b0000) begin
                  code_q  <= sel;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (ack) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
`ifdef ONEHOT_REQ_ENCODER_RR_EN
                  ptr_q   <= code_q;
`endif
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign code    = code_q;
   assign valid   = valid_q;
   assign pending = pending_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_onehot_req_encoder.sv
// Self-checking bench for onehot_req_encoder: vector table with a grant scoreboard plus corner-case sequences.
module tb_onehot_req_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic       ack;
   logic [1:0] code;
   logic       valid;
   logic [3:0] pending;
   logic       overrun;

   int n_tests = 0;
   int n_fail  = 0;

   logic [1:0] exp_q[$];

   typedef struct {
      logic [3:0] req;
      int         n;
      logic [7:0] codes;
      int         ack_delay;
   } vec_t;

   vec_t vecs[6];

   onehot_req_encoder dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .ack     (ack),
      .code    (code),
      .valid   (valid),
      .pending (pending),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      ack   = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_valid(input int budget, input string name);
      int c;
      c = 0;
      while (!valid && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({name, " valid"}, 32'(valid), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [3:0] rem;
      logic [1:0] e;
      logic [7:0] cs;
      do_reset();
      cs  = v.codes;
      rem = v.req;
      for (int j = 0; j < v.n; j++) exp_q.push_back(cs[2*j +: 2]);
      req = v.req;
      @(negedge clk);
      req = 4'b0000;
      while (exp_q.size() > 0) begin
         wait_valid(8, "vec grant");
         if (!valid) break;
         e = exp_q.pop_front();
         check("vec code", 32'(code), 32'(e));
         for (int d = 0; d < v.ack_delay; d++) begin
            @(negedge clk);
            check("vec hold", 32'({valid, code}), 32'({1'b1, e}));
         end
         ack = 1'b1;
         @(negedge clk);
         ack = 1'b0;
         rem[e] = 1'b0;
         check("vec drop", 32'(valid), 32'd0);
         check("vec pending", 32'(pending), 32'(rem));
      end
      check("vec drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check("vec overrun", 32'(overrun), 32'd0);
   endtask

   initial begin
      vecs[0] = '{req: 4'b0100, n: 1, codes: 8'b00_00_00_10, ack_delay: 0};
      vecs[1] = '{req: 4'b1001, n: 2, codes: 8'b00_00_00_11, ack_delay: 5};
      vecs[2] = '{req: 4'b1111, n: 4, codes: 8'b00_01_10_11, ack_delay: 1};
      vecs[3] = '{req: 4'b0011, n: 2, codes: 8'b00_00_00_01, ack_delay: 2};
      vecs[4] = '{req: 4'b1010, n: 2, codes: 8'b00_00_01_11, ack_delay: 0};
      vecs[5] = '{req: 4'b0001, n: 1, codes: 8'b00_00_00_00, ack_delay: 3};

      // reset values, and ack with nothing presented must be ignored
      reset = 1'b1;
      req   = 4'b0000;
      ack   = 1'b0;
      #3;
      check("rst code", 32'(code), 32'd0);
      check("rst valid", 32'(valid), 32'd0);
      check("rst pending", 32'(pending), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ack   = 1'b1;
      repeat (3) @(negedge clk);
      check("idle ack", 32'({valid, pending, overrun}), 32'd0);
      ack = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // same-edge ack and re-request of the granted bit: set wins, no overrun
      do_reset();
      req = 4'b0100;
      @(negedge clk);
      req = 4'b0000;
      wait_valid(8, "sw grant");
      check("sw code", 32'(code), 32'd2);
      ack = 1'b1;
      req = 4'b0100;
      @(negedge clk);
      ack = 1'b0;
      req = 4'b0000;
      check("sw valid", 32'(valid), 32'd0);
      check("sw pending", 32'(pending), 32'h4);
      check("sw overrun", 32'(overrun), 32'd0);
      @(negedge clk);
      check("sw regrant", 32'({valid, code}), 32'({1'b1, 2'b10}));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      check("sw clear", 32'(pending), 32'd0);

      // re-request of a still-pending bit is sticky until reset
      do_reset();
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0000;
      wait_valid(8, "ov grant");
      req = 4'b0010;
      @(negedge clk);
      req = 4'b0000;
      check("ov set", 32'(overrun), 32'd1);
      check("ov present", 32'({valid, code, pending}), 32'({1'b1, 2'b01, 4'b0010}));
      ack = 1'b1;
      repeat (4) @(negedge clk);
      ack = 1'b0;
      check("ov sticky", 32'(overrun), 32'd1);
      reset = 1'b1;
      #1;
      check("ov reset", 32'(overrun), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // all requests held with ack held: priority rotation (or repeated top grant)
      do_reset();
`ifdef ONEHOT_REQ_ENCODER_RR_EN
      exp_q = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
      exp_q = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
      req = 4'b1111;
      ack = 1'b1;
      for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (valid) check("rot code", 32'(code), 32'(exp_q.pop_front()));
      end
      check("rot drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      check("rot overrun", 32'(overrun), 32'd1);
      req = 4'b0000;
      ack = 1'b0;

      // asynchronous reset between edges while presenting
      do_reset();
      req = 4'b1010;
      @(negedge clk);
      req = 4'b0000;
      wait_valid(8, "ar grant");
      check("ar pre", 32'({code, pending}), 32'({2'b11, 4'b1010}));
      #2;
      reset = 1'b1;
      #1;
      check("ar clear", 32'({valid, code, pending, overrun}), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
